// File: rtl/alu_mdu.sv
// Execute-stage ALU with optional iterative RV32M multiply/divide.
// Base ops finish at the edge that accepts them; M ops run IDLE -> MUL/DIV -> FIX over XLEN+1 cycles.
module alu_mdu #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      fun7,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] res,
    output logic            zero,
    output logic            neg,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t r_state;
    state_t w_next;

    logic [SW-1:0]     r_cnt;
    logic [2:0]        r_fun3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_am;
    logic [XLEN-1:0]   r_bm;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_rem;
    logic              r_sneg;
    logic              r_aneg;
    logic              r_div0;

    logic              w_accept;
    logic              w_m_op;
    logic [SW-1:0]     w_shamt;
    logic [XLEN-1:0]   w_base;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_remv;
    logic [XLEN-1:0]   w_fix;
    logic              w_unused;

    // Handshake: a request is taken on any rising edge where start=1 and busy=0;
    // completion is the single-cycle done pulse, with res/zero/neg valid from then on.
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = start && (r_state == S_IDLE);
    assign w_m_op    = ENABLE_M && fun7[0];
    assign w_shamt   = rs2[SW-1:0];
    assign dbg_state = r_state;
    assign w_unused  = &{1'b0, fun7[6], fun7[4:1]};

    always_comb begin
        w_base = '0;
        case (fun3)
            3'b000: w_base = fun7[5] ? (rs1 - rs2) : (rs1 + rs2);
            3'b001: w_base = rs1 << w_shamt;
            3'b010: w_base = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            3'b011: w_base = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            3'b100: w_base = rs1 ^ rs2;
            3'b101: w_base = fun7[5] ? $unsigned($signed(rs1) >>> w_shamt) : (rs1 >> w_shamt);
            3'b110: w_base = rs1 | rs2;
            default: w_base = rs1 & rs2;
        endcase
        // M-group encodings without the multiplier/divider retire as a zero result.
        if (fun7[0]) w_base = '0;
    end

    // Signedness: MULH/MULHSU take rs1 signed, MULH takes rs2 signed, DIV/REM take both.
    assign w_a_neg = rs1[XLEN-1] && (fun3[2] ? !fun3[0] : (fun3[1:0] == 2'b01 || fun3[1:0] == 2'b10));
    assign w_b_neg = rs2[XLEN-1] && (fun3[2] ? !fun3[0] : (fun3[1:0] == 2'b01));
    assign w_a_mag = w_a_neg ? -rs1 : rs1;
    assign w_b_mag = w_b_neg ? -rs2 : rs2;

    assign w_msum = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_am} : {(XLEN+1){1'b0}});
    assign w_rsh  = {r_rem, r_q[XLEN-1]};
    assign w_diff = w_rsh - {1'b0, r_bm};

    assign w_prod = r_sneg ? -r_p : r_p;
    assign w_quo  = r_sneg ? -r_q : r_q;
    assign w_remv = r_aneg ? -r_rem : r_rem;

    always_comb begin
        w_fix = '0;
        case (r_fun3)
            3'b000:          w_fix = w_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          w_fix = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  w_fix = r_div0 ? '1 : w_quo;
            default:         w_fix = r_div0 ? r_a : w_remv;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (w_accept && w_m_op) w_next = fun3[2] ? S_DIV : S_MUL;
            S_MUL, S_DIV:  if (r_cnt == SW'(XLEN-1)) w_next = S_FIX;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res    <= '0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            done   <= 1'b0;
            r_cnt  <= '0;
            r_fun3 <= '0;
            r_a    <= '0;
            r_am   <= '0;
            r_bm   <= '0;
            r_p    <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_sneg <= 1'b0;
            r_aneg <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_m_op) begin
                        r_fun3 <= fun3;
                        r_a    <= rs1;
                        r_am   <= w_a_mag;
                        r_bm   <= w_b_mag;
                        r_p    <= {{XLEN{1'b0}}, w_b_mag};
                        r_q    <= w_a_mag;
                        r_rem  <= '0;
                        r_sneg <= w_a_neg ^ w_b_neg;
                        r_aneg <= w_a_neg;
                        r_div0 <= (rs2 == '0);
                        r_cnt  <= '0;
                    end else if (w_accept) begin
                        res  <= w_base;
                        zero <= (w_base == '0);
                        neg  <= w_base[XLEN-1];
                        done <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_p   <= {w_msum, r_p[XLEN-1:1]};
                    r_cnt <= r_cnt + SW'(1);
                end
                S_DIV: begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!w_diff[XLEN]) begin
                        r_rem <= w_diff[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rsh[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + SW'(1);
                end
                default: begin
                    res   <= w_fix;
                    zero  <= (w_fix == '0);
                    neg   <= w_fix[XLEN-1];
                    done  <= 1'b1;
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: a 32-bit instance with M ops and a 16-bit base-only instance.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  fun7 = '0;
    logic [2:0]  fun3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] res;
    logic        zero, neg, busy, done;
    logic [1:0]  dbg_state;

    logic        s_start = 1'b0;
    logic [6:0]  s_fun7 = '0;
    logic [2:0]  s_fun3 = '0;
    logic [15:0] s_rs1 = '0;
    logic [15:0] s_rs2 = '0;
    logic [15:0] s_res;
    logic        s_zero, s_neg, s_busy, s_done;
    logic [1:0]  s_dbg_state;

    int errors = 0;
    int checks = 0;

    alu_mdu #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .fun7(fun7), .fun3(fun3),
        .rs1(rs1), .rs2(rs2), .res(res), .zero(zero), .neg(neg),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    alu_mdu #(.XLEN(16), .ENABLE_M(1'b0)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .fun7(s_fun7), .fun3(s_fun3),
        .rs1(s_rs1), .rs2(s_rs2), .res(s_res), .zero(s_zero), .neg(s_neg),
        .busy(s_busy), .done(s_done), .dbg_state(s_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref32(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        if (!f7[0]) begin
            case (f3)
                3'd0: return f7[5] ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return (sa < sb) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = 64'(sa / sb); return p[31:0]; end
            3'd5: begin if (b == 0) return '1; return a / b; end
            3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic logic [15:0] ref16(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [3:0] sh;
        sh = b[3:0];
        if (f7[0]) return '0;
        case (f3)
            3'd0: return f7[5] ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd3: return (a < b) ? 16'd1 : 16'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // One op on the 32-bit instance; poke>=0 re-pulses start with fresh operands at that busy cycle.
    task automatic run32(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input string tag, input int poke);
        logic [31:0] exp;
        int          cyc;
        bit          is_m;
        bit          held_busy;
        exp = ref32(f7, f3, a, b);
        is_m = f7[0];
        held_busy = 1'b1;
        @(negedge clk);
        start = 1'b1; fun7 = f7; fun3 = f3; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0; fun7 = 7'($urandom); fun3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) held_busy = 1'b0;
            if (cyc == poke) begin
                start = 1'b1; fun7 = 7'h01; fun3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), is_m ? 64'd33 : 64'd0);
        if (is_m) chk({tag, "_busy_held"}, 64'(held_busy), 64'd1);
        chk({tag, "_res"}, 64'(res), 64'(exp));
        chk({tag, "_zero"}, 64'(zero), 64'(exp == 0));
        chk({tag, "_neg"}, 64'(neg), 64'(exp[31]));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run16(input logic [6:0] f7, input logic [2:0] f3, input logic [15:0] a,
                         input logic [15:0] b, input string tag);
        logic [15:0] exp;
        exp = ref16(f7, f3, a, b);
        @(negedge clk);
        s_start = 1'b1; s_fun7 = f7; s_fun3 = f3; s_rs1 = a; s_rs2 = b;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk({tag, "_done"}, 64'(s_done), 64'd1);
        chk({tag, "_res"}, 64'(s_res), 64'(exp));
        chk({tag, "_zero"}, 64'(s_zero), 64'(exp == 0));
        chk({tag, "_neg"}, 64'(s_neg), 64'(exp[15]));
        chk({tag, "_busy"}, 64'(s_busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(s_done), 64'd0);
    endtask

    initial begin
        logic [31:0] exp;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        bit          saw_done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_neg", 64'(neg), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst16_res", 64'(s_res), 64'd0);
        chk("rst16_zero", 64'(s_zero), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        run32(7'h00, 3'd0, 32'd5, 32'd7, "add", -1);
        run32(7'h20, 3'd0, 32'd3, 32'd5, "sub", -1);
        run32(7'h20, 3'd5, 32'h8000_0000, 32'h21, "sra", -1);
        run32(7'h00, 3'd5, 32'h8000_0000, 32'h21, "srl", -1);
        run32(7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, "slt", -1);
        run32(7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, "sltu", -1);
        run32(7'h01, 3'd1, 32'h8000_0000, 32'h8000_0000, "mulh", -1);
        run32(7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", -1);
        run32(7'h01, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul", -1);
        run32(7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, "div", -1);
        run32(7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem", -1);
        run32(7'h01, 3'd5, 32'd10, 32'd0, "divu_by0", -1);
        run32(7'h01, 3'd6, 32'd10, 32'd0, "rem_by0", -1);
        run32(7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1);
        run32(7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", -1);
        run32(7'h01, 3'd4, 32'd100, 32'd7, "div_ignore_start", 10);

        // Back-to-back base ops, one accepted per edge.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            f3 = 3'($urandom);
            a = pick32(); b = pick32();
            exp = ref32(f7, f3, a, b);
            start = 1'b1; fun7 = f7; fun3 = f3; rs1 = a; rs2 = b;
            @(posedge clk); #1;
            chk("b2b_done", 64'(done), 64'd1);
            chk("b2b_res", 64'(res), 64'(exp));
        end
        start = 1'b0;

        // Reset around cycle 20 of a MUL discards it.
        run32(7'h20, 3'd0, 32'd3, 32'd5, "pre_reset", -1);
        @(negedge clk);
        start = 1'b1; fun7 = 7'h01; fun3 = 3'd0; rs1 = 32'd12345; rs2 = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_res", 64'(res), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        chk("midrst_neg", 64'(neg), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);

        for (int i = 0; i < 150; i++) begin
            f7 = {1'b0, 1'($urandom_range(0, 1)), 4'b0000, 1'($urandom_range(0, 1))};
            run32(f7, 3'($urandom), pick32(), pick32(), "rand32", -1);
        end

        run16(7'h00, 3'd0, 16'hFFFF, 16'd1, "add16_wrap");
        run16(7'h01, 3'd0, 16'd5, 16'd3, "mul16_disabled");
        run16(7'h20, 3'd0, 16'd3, 16'd5, "sub16");
        run16(7'h20, 3'd5, 16'h8000, 16'h0011, "sra16");
        for (int i = 0; i < 40; i++) begin
            f7 = {1'b0, 1'($urandom_range(0, 1)), 4'b0000, 1'($urandom_range(0, 1))};
            run16(f7, 3'($urandom), 16'($urandom), 16'($urandom), "rand16");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
